// File: rtl/draw_sprite_anim.sv
// Animated sprite overlay for the VGA bus: scaled, mirrored, colour-keyed sprite drawn at (xpos,ypos),
// cycling through ANIM_FRAMES images stored back-to-back in an external ROM.
module draw_sprite_anim #(
  parameter int          SRC_W        = 16,
  parameter int          SRC_H        = 16,
  parameter int          SCALE_LOG2   = 1,
  parameter int          ANIM_FRAMES  = 4,
  parameter int          FRAME_PERIOD = 8,
  parameter int          ROM_LATENCY  = 1,
  parameter int          ADDR_W       = 14,
  parameter logic [11:0] KEY_COLOUR   = 12'hFFF,
  parameter int          VGA_BUS_SIZE = 36,
  localparam int         FI_W         = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    module_en,
  input  logic                    mirror_x,
  input  logic                    mirror_y,
  input  logic                    anim_en,
  input  logic                    one_shot,
  input  logic                    anim_restart,
  input  logic [9:0]              xpos,
  input  logic [9:0]              ypos,
  input  logic [11:0]             rgb_pixel,
  input  logic [VGA_BUS_SIZE-1:0] vga_bus_in,
  output logic [VGA_BUS_SIZE-1:0] vga_bus_out,
  output logic [ADDR_W-1:0]       pixel_addr,
  output logic                    hit,
  output logic                    anim_done,
  output logic [FI_W-1:0]         frame_idx
);

  // Bus layout: {hcount[10:0], hsync, vcount[10:0], vsync, rgb[11:0]}
  localparam int HC_LO    = 25;
  localparam int VC_LO    = 13;
  localparam int VS_BIT   = 12;
  localparam int RX_W     = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int RY_W     = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam int CNT_W    = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int DISP_W   = SRC_W << SCALE_LOG2;
  localparam int DISP_H   = SRC_H << SCALE_LOG2;
  localparam int FRAME_SZ = SRC_W * SRC_H;

  typedef enum logic [1:0] {S_RUN, S_HOLD, S_DONE} state_t;

  logic [10:0]       hcount_p0, vcount_p0;
  logic              vsync_p0, tick_p0, in_p0;
  logic [11:0]       x_lo, x_hi, y_lo, y_hi, hc12, vc12, dx, dy;
  logic [RX_W-1:0]   rx;
  logic [RY_W-1:0]   ry;
  logic [ADDR_W-1:0] addr_p0;

  logic [VGA_BUS_SIZE-1:0] bus_pipe [ROM_LATENCY+1];
  logic                    in_pipe  [ROM_LATENCY+1];
  logic                    sel_out;

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;
  logic             pending, vsync_prev;

  assign hcount_p0 = vga_bus_in[HC_LO +: 11];
  assign vcount_p0 = vga_bus_in[VC_LO +: 11];
  assign vsync_p0  = vga_bus_in[VS_BIT];
  assign tick_p0   = vsync_p0 & ~vsync_prev;

  // Stage p0: region test and ROM address; 12-bit sums clip at the screen edge instead of wrapping
  always_comb begin
    hc12  = {1'b0, hcount_p0};
    vc12  = {1'b0, vcount_p0};
    x_lo  = {2'b00, xpos};
    y_lo  = {2'b00, ypos};
    x_hi  = x_lo + 12'(DISP_W);
    y_hi  = y_lo + 12'(DISP_H);
    in_p0 = (hc12 >= x_lo) && (hc12 < x_hi) && (vc12 >= y_lo) && (vc12 < y_hi);
    dx    = hc12 - x_lo;
    dy    = vc12 - y_lo;
    rx    = RX_W'(dx >> SCALE_LOG2);
    ry    = RY_W'(dy >> SCALE_LOG2);
    if (mirror_x) rx = RX_W'(SRC_W - 1) - rx;
    if (mirror_y) ry = RY_W'(SRC_H - 1) - ry;
    addr_p0 = '0;
    if (in_p0)
      addr_p0 = ADDR_W'(FRAME_SZ) * ADDR_W'(frame_idx) + ADDR_W'(ry) * ADDR_W'(SRC_W) + ADDR_W'(rx);
  end

  assign sel_out = in_pipe[ROM_LATENCY] & module_en & (rgb_pixel != KEY_COLOUR);

  // Stage p1..pN: bus and region flag wait for ROM data, then the overlay output register
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_addr  <= '0;
      vga_bus_out <= '0;
      hit         <= 1'b0;
      for (int i = 0; i <= ROM_LATENCY; i++) begin
        bus_pipe[i] <= '0;
        in_pipe[i]  <= 1'b0;
      end
    end else begin
      pixel_addr  <= addr_p0;
      bus_pipe[0] <= vga_bus_in;
      in_pipe[0]  <= in_p0;
      for (int i = 1; i <= ROM_LATENCY; i++) begin
        bus_pipe[i] <= bus_pipe[i-1];
        in_pipe[i]  <= in_pipe[i-1];
      end
      vga_bus_out <= {bus_pipe[ROM_LATENCY][VGA_BUS_SIZE-1:12],
                      sel_out ? rgb_pixel : bus_pipe[ROM_LATENCY][11:0]};
      hit         <= sel_out;
    end
  end

  // Animation sequencer, stepped once per vsync rising edge; a pending restart wins over advancing
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      frame_idx  <= '0;
      frame_cnt  <= '0;
      anim_done  <= 1'b0;
      pending    <= 1'b0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync_p0;
      if (tick_p0 && (pending || anim_restart)) begin
        frame_idx <= '0;
        frame_cnt <= '0;
        anim_done <= 1'b0;
        pending   <= 1'b0;
        state     <= anim_en ? S_RUN : S_HOLD;
      end else begin
        if (anim_restart) pending <= 1'b1;
        case (state)
          S_RUN: begin
            if (!anim_en) begin
              state <= S_HOLD;
            end else if (tick_p0) begin
              if (frame_cnt == CNT_W'(FRAME_PERIOD - 1)) begin
                frame_cnt <= '0;
                if (frame_idx == FI_W'(ANIM_FRAMES - 1)) begin
                  if (one_shot) begin
                    state     <= S_DONE;
                    anim_done <= 1'b1;
                  end else begin
                    frame_idx <= '0;
                  end
                end else begin
                  frame_idx <= frame_idx + FI_W'(1);
                end
              end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
              end
            end
          end
          S_HOLD: if (anim_en) state <= S_RUN;
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_draw_sprite_anim.sv
// Bench for draw_sprite_anim: two instances (scale 1x and 2x) fed from a shared ROM model,
// expected outputs queued at stimulus time and compared by a monitor at the fixed output latency.
module tb_draw_sprite_anim;

  localparam int BW = 36;

  logic          clk = 1'b0;
  logic          rst, module_en, mirror_x, mirror_y, anim_en, one_shot, anim_restart;
  logic [9:0]    xpos, ypos;
  logic [BW-1:0] bus_in;
  logic [11:0]   rgb0, rgb1;
  logic [BW-1:0] out0, out1;
  logic [13:0]   addr0, addr1;
  logic          hit0, hit1, done0, done1;
  logic [1:0]    fi0, fi1;
  logic [11:0]   rom [16384];

  always #5 clk = ~clk;

  draw_sprite_anim #(.SCALE_LOG2(0), .FRAME_PERIOD(2)) u_dut0 (
    .clk(clk), .rst(rst), .module_en(module_en), .mirror_x(mirror_x), .mirror_y(mirror_y),
    .anim_en(anim_en), .one_shot(one_shot), .anim_restart(anim_restart),
    .xpos(xpos), .ypos(ypos), .rgb_pixel(rgb0), .vga_bus_in(bus_in), .vga_bus_out(out0),
    .pixel_addr(addr0), .hit(hit0), .anim_done(done0), .frame_idx(fi0));

  draw_sprite_anim #(.SCALE_LOG2(1), .FRAME_PERIOD(2)) u_dut1 (
    .clk(clk), .rst(rst), .module_en(module_en), .mirror_x(mirror_x), .mirror_y(mirror_y),
    .anim_en(anim_en), .one_shot(one_shot), .anim_restart(anim_restart),
    .xpos(xpos), .ypos(ypos), .rgb_pixel(rgb1), .vga_bus_in(bus_in), .vga_bus_out(out1),
    .pixel_addr(addr1), .hit(hit1), .anim_done(done1), .frame_idx(fi1));

  always @(posedge clk) begin
    rgb0 <= rom[addr0];
    rgb1 <= rom[addr1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [BW-1:0] bus;
    logic [13:0]   addr;
    logic          hit;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [BW-1:0] mk_bus(input int hc, input int vc, input logic vs);
    logic [10:0] h, v;
    h = 11'(hc);
    v = 11'(vc);
    return {h, h[0], v, vs, 4'h3, v[3:0], h[3:0]};
  endfunction

  function automatic logic hit_of(input logic inr, input logic [13:0] a);
    return inr && module_en && (rom[a] != 12'hFFF);
  endfunction

  // Monitor: pixel_addr is seen two negedges before the matching bus output
  logic [13:0] a0_h0, a0_h1, a1_h0, a1_h1;
  always @(negedge clk) begin
    exp_t e;
    a0_h0 <= addr0;
    a0_h1 <= a0_h0;
    a1_h0 <= addr1;
    a1_h1 <= a1_h0;
    if (q0.size() > 0 && q0[0].cyc + 3 == cyc) begin
      e = q0.pop_front();
      check("dut0 bus", out0, e.bus);
      check("dut0 addr", a0_h1, e.addr);
      check("dut0 hit", hit0, e.hit);
    end
    if (q1.size() > 0 && q1[0].cyc + 3 == cyc) begin
      e = q1.pop_front();
      check("dut1 bus", out1, e.bus);
      check("dut1 addr", a1_h1, e.addr);
      check("dut1 hit", hit1, e.hit);
    end
  end

  task automatic drive(input int hc, input int vc, input logic vs);
    @(posedge clk);
    #1;
    bus_in = mk_bus(hc, vc, vs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1200, 700, 1'b0);
  endtask

  task automatic push(input int d, input int hc, input int vc, input logic inr, input int a);
    exp_t e;
    e.cyc  = cyc;
    e.addr = 14'(a);
    e.hit  = hit_of(inr, e.addr);
    e.bus  = mk_bus(hc, vc, 1'b0);
    if (e.hit) e.bus[11:0] = rom[e.addr];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic pix(input int hc, input int vc, input logic in0, input int a0,
                     input logic in1, input int a1);
    drive(hc, vc, 1'b0);
    push(0, hc, vc, in0, in0 ? a0 : 0);
    push(1, hc, vc, in1, in1 ? a1 : 0);
  endtask

  task automatic vsync_pulse();
    drive(1200, 700, 1'b1);
    drive(1200, 700, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fexp;
    rst = 1'b1; module_en = 1'b1; mirror_x = 1'b0; mirror_y = 1'b0;
    anim_en = 1'b0; one_shot = 1'b0; anim_restart = 1'b0;
    xpos = 10'd100; ypos = 10'd50;
    bus_in = mk_bus(1200, 700, 1'b0);
    for (int a = 0; a < 16384; a++) rom[a] = 12'(a) ^ 12'h800;

    repeat (3) @(posedge clk);
    #1;
    check("reset bus", out0, 0);
    check("reset addr", addr0, 0);
    check("reset hit", hit0, 0);
    check("reset done", done0, 0);
    check("reset frame", fi0, 0);
    rst = 1'b0;
    idle(2);

    // 1x / 2x straight copy along one line, including the edges of both sprites
    for (int hc = 98; hc <= 117; hc++)
      pix(hc, 50, hc >= 100 && hc < 116, hc - 100, hc >= 100 && hc < 132, (hc - 100) / 2);
    idle(4);

    // both mirrors: first screen pixel maps to the last texel
    mirror_x = 1'b1; mirror_y = 1'b1;
    for (int vc = 50; vc <= 52; vc++)
      for (int hc = 100; hc <= 103; hc++)
        pix(hc, vc, 1'b1, (15 - (vc - 50)) * 16 + (15 - (hc - 100)),
            1'b1, (15 - (vc - 50) / 2) * 16 + (15 - (hc - 100) / 2));
    idle(4);

    // colour key at texel 20, then module disabled
    mirror_x = 1'b0; mirror_y = 1'b0;
    rom[20] = 12'hFFF;
    for (int vc = 51; vc <= 52; vc++)
      for (int hc = 103; hc <= 109; hc++)
        pix(hc, vc, 1'b1, (vc - 50) * 16 + (hc - 100), 1'b1, ((vc - 50) / 2) * 16 + (hc - 100) / 2);
    idle(4);
    module_en = 1'b0;
    for (int hc = 103; hc <= 106; hc++)
      pix(hc, 51, 1'b1, 16 + (hc - 100), 1'b1, (hc - 100) / 2);
    idle(4);
    module_en = 1'b1;
    rom[20] = 12'(20) ^ 12'h800;

    // looping animation, two vsyncs per image
    anim_en = 1'b1;
    idle(1);
    for (int n = 1; n <= 8; n++) begin
      vsync_pulse();
      fexp = (n / 2) % 4;
      check("loop frame_idx", fi0, fexp);
      check("loop frame_idx x2", fi1, fexp);
      if (n % 2 == 0) pix(100, 50, 1'b1, fexp * 256, 1'b1, fexp * 256);
    end
    idle(4);

    // one-shot: stops on frame 3 with anim_done, restart applies at the next vsync
    one_shot = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      vsync_pulse();
      check("oneshot frame_idx", fi0, (n >= 8) ? 3 : (n / 2) % 4);
      check("oneshot done", done0, n >= 8);
    end
    @(posedge clk); #1 anim_restart = 1'b1;
    @(posedge clk); #1 anim_restart = 1'b0;
    idle(2);
    check("restart pending frame", fi0, 3);
    check("restart pending done", done0, 1);
    vsync_pulse();
    check("restart frame", fi0, 0);
    check("restart done", done0, 0);
    pix(100, 50, 1'b1, 0, 1'b1, 0);
    vsync_pulse();
    vsync_pulse();
    vsync_pulse();
    check("post-restart frame", fi0, 1);
    @(posedge clk);
    #1;
    anim_restart = 1'b1;
    bus_in = mk_bus(1200, 700, 1'b1);
    drive(1200, 700, 1'b0);
    anim_restart = 1'b0;
    check("restart on tick frame", fi0, 0);
    anim_en = 1'b0; one_shot = 1'b0;
    idle(4);

    // right-edge clipping: no wrap to column 0
    xpos = 10'd1020;
    for (int hc = 1018; hc <= 1023; hc++)
      pix(hc, 50, hc >= 1020, hc - 1020, hc >= 1020, (hc - 1020) / 2);
    for (int hc = 0; hc <= 3; hc++)
      pix(hc, 50, 1'b0, 0, 1'b0, 0);
    idle(4);

    // reset mid-line with a non-zero frame and address in flight
    xpos = 10'd100;
    anim_en = 1'b1;
    idle(1);
    vsync_pulse();
    vsync_pulse();
    check("pre-reset frame", fi0, 1);
    anim_en = 1'b0;
    drive(105, 50, 1'b0);
    drive(105, 50, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid-line reset bus0", out0, 0);
    check("mid-line reset bus1", out1, 0);
    check("mid-line reset addr", addr0, 0);
    check("mid-line reset hit", hit0, 0);
    check("mid-line reset frame", fi0, 0);
    check("mid-line reset done", done0, 0);
    rst = 1'b0;
    for (int hc = 100; hc <= 103; hc++)
      pix(hc, 50, 1'b1, hc - 100, 1'b1, (hc - 100) / 2);
    idle(6);

    check("dut0 queue drained", q0.size(), 0);
    check("dut1 queue drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
